// File: rtl/vga_pixel_out.sv
// 640x480@60 VGA output stage: timing generator, pixel request to the RGB555
// processor, latency-matched sync/blank pipeline and RGB555 -> RGB888 expansion.
module vga_pixel_out #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int PROC_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [14:0] i_data,
    output logic        o_is_new_read,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_vga_hs,
    output logic        o_vga_vs,
    output logic        o_vga_blank_n,
    output logic [10:0] o_h_cnt,
    output logic [10:0] o_v_cnt,
    output logic        o_frame_start
);

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BACK + V_ACTIVE);

    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hs_raw, vs_raw, act_raw;
    logic        req_q, req_d;
    logic        frame_start_q, frame_start_d;

    // Stage 0 lines up with o_is_new_read; stage PROC_LAT lines up with valid i_data.
    logic [PROC_LAT:0] hs_pipe_q, hs_pipe_d;
    logic [PROC_LAT:0] vs_pipe_q, vs_pipe_d;
    logic [PROC_LAT:0] act_pipe_q, act_pipe_d;

    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
        end
    end

    always_comb begin
        hs_raw  = (h_q >= H_SYNC_END);
        vs_raw  = (v_q >= V_SYNC_END);
        act_raw = (h_q >= H_ACT_START) && (h_q < H_ACT_END) &&
                  (v_q >= V_ACT_START) && (v_q < V_ACT_END);
    end

    always_comb begin
        req_d         = act_raw;
        frame_start_d = (h_q == '0) && (v_q == '0);
        hs_pipe_d     = {hs_pipe_q[PROC_LAT-1:0], hs_raw};
        vs_pipe_d     = {vs_pipe_q[PROC_LAT-1:0], vs_raw};
        act_pipe_d    = {act_pipe_q[PROC_LAT-1:0], act_raw};
    end

    always_comb begin
        hs_d      = hs_pipe_q[PROC_LAT];
        vs_d      = vs_pipe_q[PROC_LAT];
        blank_n_d = act_pipe_q[PROC_LAT];
        r_d       = '0;
        g_d       = '0;
        b_d       = '0;
        // Outside the visible window i_data is ignored entirely.
        if (act_pipe_q[PROC_LAT]) begin
            r_d = expand5(i_data[14:10]);
            g_d = expand5(i_data[9:5]);
            b_d = expand5(i_data[4:0]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q           <= '0;
            v_q           <= '0;
            req_q         <= 1'b0;
            frame_start_q <= 1'b0;
            // NOTE: the delay pipeline is reset too, so a request in flight at reset never surfaces.
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            act_pipe_q    <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            req_q         <= req_d;
            frame_start_q <= frame_start_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            act_pipe_q    <= act_pipe_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
        end
    end

    assign o_is_new_read = req_q;
    assign o_vga_r       = r_q;
    assign o_vga_g       = g_q;
    assign o_vga_b       = b_q;
    assign o_vga_hs      = hs_q;
    assign o_vga_vs      = vs_q;
    assign o_vga_blank_n = blank_n_q;
    assign o_h_cnt       = h_q;
    assign o_v_cnt       = v_q;
    assign o_frame_start = frame_start_q;

endmodule
